// File: rtl/tinytester_pkg.sv
// tinytester_pkg
// Shared definitions for the tinytester_seq pad sequencer: the one-hot state
// encodings seen on state_o and the default parameter values used by the
// sequencer and its phase counter.
// Ports: none (package).
// Build option: TINYTESTER_SEQ_COMPARE_EN (see tinytester_seq.sv).

package tinytester_pkg;

  // One-hot state encodings, bit order {WAIT, RUN, IDLE}
  localparam logic [2:0] ST_IDLE = 3'b001;
  localparam logic [2:0] ST_RUN  = 3'b010;
  localparam logic [2:0] ST_WAIT = 3'b100;

  // Default parameter values
  localparam int DEF_WIDTH      = 32;
  localparam int DEF_NUM_PHASES = 4;
  localparam int DEF_PH_W       = 4;
  localparam int DEF_LEN_W      = 8;
  localparam int DEF_REP_W      = 16;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_WAIT = ST_WAIT
  } state_t;

endpackage

// File: rtl/tinytester_phase_ctr.sv
// tinytester_phase_ctr
// Hold / phase / iteration counters for one tinytester_seq run.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   clear_i           zero all counters (run start)
//   en_i              advance the counters this cycle (RUN, not aborting)
//   len_i             latched hold length (phase lasts len_i+1 cycles)
//   rep_i             latched repeat count (repeat_i+1 iterations)
//   phase_idx_o       current phase index
//   phase_last_o      current cycle is the last cycle of the phase
//   run_last_o        current cycle is the last cycle of the whole run

module tinytester_phase_ctr
  import tinytester_pkg::*;
#(
  parameter int NUM_PHASES = DEF_NUM_PHASES,
  parameter int PH_W       = DEF_PH_W,
  parameter int LEN_W      = DEF_LEN_W,
  parameter int REP_W      = DEF_REP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [REP_W-1:0] rep_i,
  output logic [PH_W-1:0]  phase_idx_o,
  output logic             phase_last_o,
  output logic             run_last_o
);

  localparam logic [PH_W-1:0] LAST_PH = PH_W'(NUM_PHASES - 1);

  logic [LEN_W-1:0] hold_q;
  logic [PH_W-1:0]  phase_q;
  logic [REP_W-1:0] iter_q;
  logic             last_phase;

  assign phase_last_o = (hold_q == len_i);
  assign last_phase   = (phase_q == LAST_PH);
  assign run_last_o   = phase_last_o && last_phase && (iter_q == rep_i);
  assign phase_idx_o  = phase_q;

  // Counter update: the hold counter runs up to the latched length, then the
  // phase advances; after the final phase the iteration counter advances and
  // the phase wraps. On the very last cycle of the run nothing moves, the
  // counters simply freeze until the next clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q  <= '0;
      phase_q <= '0;
      iter_q  <= '0;
    end else if (clear_i) begin
      hold_q  <= '0;
      phase_q <= '0;
      iter_q  <= '0;
    end else if (en_i) begin
      if (!phase_last_o) begin
        hold_q <= hold_q + LEN_W'(1);
      end else if (!last_phase) begin
        phase_q <= phase_q + PH_W'(1);
        hold_q  <= '0;
      end else if (iter_q != rep_i) begin
        iter_q  <= iter_q + REP_W'(1);
        phase_q <= '0;
        hold_q  <= '0;
      end
    end
  end

endmodule

// File: rtl/tinytester_seq.sv
// tinytester_seq
// Drives a WIDTH-bit pad bus through NUM_PHASES programmable phases with a
// programmable per-phase hold time, repeat count, selectable capture phase
// and an abort input. Sits between the register bank and the pad ring.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   start_i            level; starts a run from IDLE, must drop before rerun
//   abort_i            level; ends a run (only honoured in RUN)
//   phase_len_i        per-phase hold length (len+1 cycles), latched at start
//   repeat_i           iteration count minus one, latched at start
//   capture_phase_i    phase whose last cycle samples padin_i, latched at start
//   dataout_i, oe_i    output pattern and pad enables
//   active_on_i        per-phase masks, slice k = [k*WIDTH +: WIDTH]
//   padout_o, padoe_o  pad data / enable
//   padin_i, datain_o  pad input and its captured copy
//   busy_o, done_o     high in RUN / WAIT
//   state_o            one-hot {WAIT, RUN, IDLE}
// Build option TINYTESTER_SEQ_COMPARE_EN adds expect_i, cmpmask_i and the
// sticky mismatch_o flag evaluated at every capture.

module tinytester_seq
  import tinytester_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int NUM_PHASES = DEF_NUM_PHASES,
  parameter int PH_W       = DEF_PH_W,
  parameter int LEN_W      = DEF_LEN_W,
  parameter int REP_W      = DEF_REP_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_i,
  input  logic                        abort_i,
  input  logic [LEN_W-1:0]            phase_len_i,
  input  logic [REP_W-1:0]            repeat_i,
  input  logic [PH_W-1:0]             capture_phase_i,
  input  logic [WIDTH-1:0]            dataout_i,
  input  logic [WIDTH-1:0]            oe_i,
  input  logic [NUM_PHASES*WIDTH-1:0] active_on_i,
  output logic [WIDTH-1:0]            padout_o,
  output logic [WIDTH-1:0]            padoe_o,
  input  logic [WIDTH-1:0]            padin_i,
  output logic [WIDTH-1:0]            datain_o,
`ifdef TINYTESTER_SEQ_COMPARE_EN
  input  logic [WIDTH-1:0]            expect_i,
  input  logic [WIDTH-1:0]            cmpmask_i,
  output logic                        mismatch_o,
`endif
  output logic                        busy_o,
  output logic                        done_o,
  output logic [2:0]                  state_o
);

  localparam logic [PH_W-1:0] LAST_PH = PH_W'(NUM_PHASES - 1);

  state_t           state_q;
  state_t           state_d;

  logic [LEN_W-1:0] len_q;
  logic [REP_W-1:0] rep_q;
  logic [PH_W-1:0]  cap_q;

  logic             start_run;
  logic             running;
  logic [PH_W-1:0]  phase_idx;
  logic             phase_last;
  logic             run_last;
  logic [PH_W-1:0]  next_phase;
  logic [PH_W-1:0]  entry_phase;
  logic [WIDTH-1:0] entry_mask;
  logic             capture_hit;

  assign start_run = (state_q == S_IDLE) && start_i;
  assign running   = (state_q == S_RUN) && !abort_i;

  tinytester_phase_ctr #(
    .NUM_PHASES (NUM_PHASES),
    .PH_W       (PH_W),
    .LEN_W      (LEN_W),
    .REP_W      (REP_W)
  ) u_phase_ctr (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (start_run),
    .en_i         (running),
    .len_i        (len_q),
    .rep_i        (rep_q),
    .phase_idx_o  (phase_idx),
    .phase_last_o (phase_last),
    .run_last_o   (run_last)
  );

  assign next_phase  = (phase_idx == LAST_PH) ? '0 : phase_idx + PH_W'(1);
  // An out-of-range capture phase can never match a live phase index, so no
  // capture happens and datain_o keeps its value.
  assign capture_hit = phase_last && (phase_idx == cap_q);

  // Mask for the phase being entered: phase 0 at run start, otherwise the
  // phase following the current one. The mask bus is sampled live here.
  always_comb begin
    entry_phase = next_phase;
    if (state_q == S_IDLE) begin
      entry_phase = '0;
    end
    entry_mask = '0;
    for (int k = 0; k < NUM_PHASES; k++) begin
      if (entry_phase == PH_W'(k)) begin
        entry_mask = active_on_i[k*WIDTH +: WIDTH];
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: abort wins over the normal end of run; WAIT holds
  // until start_i drops so a held start cannot retrigger a run.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_i) state_d = S_RUN;
      S_RUN:  if (abort_i || run_last) state_d = S_WAIT;
      S_WAIT: if (!start_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    busy_o  = (state_q == S_RUN);
    done_o  = (state_q == S_WAIT);
    state_o = state_q;
  end

  // Run datapath: latch the run configuration and the first pad drive at
  // start, then update the pads and capture at each phase boundary. An
  // abort only releases the pad enables; data and capture are untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q      <= '0;
      rep_q      <= '0;
      cap_q      <= '0;
      padout_o   <= '0;
      padoe_o    <= '0;
      datain_o   <= '0;
`ifdef TINYTESTER_SEQ_COMPARE_EN
      mismatch_o <= 1'b0;
`endif
    end else if (start_run) begin
      len_q      <= phase_len_i;
      rep_q      <= repeat_i;
      cap_q      <= capture_phase_i;
      padout_o   <= dataout_i & entry_mask;
      padoe_o    <= oe_i;
`ifdef TINYTESTER_SEQ_COMPARE_EN
      mismatch_o <= 1'b0;
`endif
    end else if (state_q == S_RUN) begin
      if (abort_i) begin
        padoe_o <= '0;
      end else if (phase_last) begin
        if (capture_hit) begin
          datain_o <= padin_i;
`ifdef TINYTESTER_SEQ_COMPARE_EN
          if (((padin_i ^ expect_i) & cmpmask_i) != '0) begin
            mismatch_o <= 1'b1;
          end
`endif
        end
        if (!run_last) begin
          padout_o <= dataout_i & entry_mask;
        end
      end
    end
  end

endmodule

// File: tb/tb_tinytester_seq.sv
// tb_tinytester_seq
// Directed bench for tinytester_seq (WIDTH=32, NUM_PHASES=4). Expected pad
// words are queued when a run is set up and popped on each RUN cycle.

module tb_tinytester_seq;

  localparam int WIDTH = 32;
  localparam int NP    = 4;
  localparam int PH_W  = 4;
  localparam int LEN_W = 8;
  localparam int REP_W = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic                start_i;
  logic                abort_i;
  logic [LEN_W-1:0]    phase_len_i;
  logic [REP_W-1:0]    repeat_i;
  logic [PH_W-1:0]     capture_phase_i;
  logic [WIDTH-1:0]    dataout_i;
  logic [WIDTH-1:0]    oe_i;
  logic [NP*WIDTH-1:0] active_on_i;
  logic [WIDTH-1:0]    padout_o;
  logic [WIDTH-1:0]    padoe_o;
  logic [WIDTH-1:0]    padin_i;
  logic [WIDTH-1:0]    datain_o;
  logic                busy_o;
  logic                done_o;
  logic [2:0]          state_o;
`ifdef TINYTESTER_SEQ_COMPARE_EN
  logic [WIDTH-1:0]    expect_i;
  logic [WIDTH-1:0]    cmpmask_i;
  logic                mismatch_o;
`endif

  logic [WIDTH-1:0] mask_tb [NP] = '{32'h1, 32'h2, 32'h4, 32'h8};
  logic [WIDTH-1:0] sb [$];
  int checks = 0;
  int errors = 0;

  tinytester_seq #(
    .WIDTH      (WIDTH),
    .NUM_PHASES (NP),
    .PH_W       (PH_W),
    .LEN_W      (LEN_W),
    .REP_W      (REP_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start_i         (start_i),
    .abort_i         (abort_i),
    .phase_len_i     (phase_len_i),
    .repeat_i        (repeat_i),
    .capture_phase_i (capture_phase_i),
    .dataout_i       (dataout_i),
    .oe_i            (oe_i),
    .active_on_i     (active_on_i),
    .padout_o        (padout_o),
    .padoe_o         (padoe_o),
    .padin_i         (padin_i),
    .datain_o        (datain_o),
`ifdef TINYTESTER_SEQ_COMPARE_EN
    .expect_i        (expect_i),
    .cmpmask_i       (cmpmask_i),
    .mismatch_o      (mismatch_o),
`endif
    .busy_o          (busy_o),
    .done_o          (done_o),
    .state_o         (state_o)
  );

  // Free-running clock, 10 time-unit period
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [WIDTH-1:0] obs,
                             input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Set up a run and queue the pad word expected on every RUN cycle
  task automatic applyStimulus(input int len, input int rep, input int cap,
                               input logic [WIDTH-1:0] dout,
                               input logic [WIDTH-1:0] oe,
                               input logic [WIDTH-1:0] pin);
    phase_len_i     = LEN_W'(len);
    repeat_i        = REP_W'(rep);
    capture_phase_i = PH_W'(cap);
    dataout_i       = dout;
    oe_i            = oe;
    padin_i         = pin;
    sb.delete();
    for (int it = 0; it <= rep; it++)
      for (int ph = 0; ph < NP; ph++)
        for (int h = 0; h <= len; h++)
          sb.push_back(dout & mask_tb[ph]);
    start_i = 1'b1;
  endtask

  // Follow a run to completion, popping one expected word per RUN cycle
  task automatic runAndScore(input string tag, input bit hold_start,
                             input int exp_cycles);
    int cycles = 0;
    logic [WIDTH-1:0] exp;
    @(negedge clk);
    start_i = hold_start;
    while (busy_o === 1'b1 && cycles < 4096) begin
      if (sb.size() > 0) exp = sb.pop_front();
      else exp = 'x;
      checkOutput({tag, "_padout"}, padout_o, exp);
      checkOutput({tag, "_padoe"}, padoe_o, oe_i);
      cycles++;
      @(negedge clk);
    end
    checkOutput({tag, "_cycles"}, WIDTH'(cycles), WIDTH'(exp_cycles));
    checkOutput({tag, "_sb_left"}, WIDTH'(sb.size()), 32'd0);
    checkOutput({tag, "_state_wait"}, WIDTH'(state_o), 32'h4);
    checkOutput({tag, "_done"}, WIDTH'(done_o), 32'h1);
    checkOutput({tag, "_padoe_hold"}, padoe_o, oe_i);
  endtask

  initial begin
    rst             = 1'b1;
    start_i         = 1'b0;
    abort_i         = 1'b0;
    phase_len_i     = '0;
    repeat_i        = '0;
    capture_phase_i = '0;
    dataout_i       = '0;
    oe_i            = '0;
    padin_i         = '0;
    active_on_i     = {mask_tb[3], mask_tb[2], mask_tb[1], mask_tb[0]};
`ifdef TINYTESTER_SEQ_COMPARE_EN
    expect_i        = '0;
    cmpmask_i       = '0;
`endif
    repeat (2) @(negedge clk);
    checkOutput("rst_state", WIDTH'(state_o), 32'h1);
    checkOutput("rst_padout", padout_o, 32'h0);
    checkOutput("rst_padoe", padoe_o, 32'h0);
    checkOutput("rst_datain", datain_o, 32'h0);
    checkOutput("rst_busy", WIDTH'(busy_o), 32'h0);
    checkOutput("rst_done", WIDTH'(done_o), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] test 1: basic run");
`ifdef TINYTESTER_SEQ_COMPARE_EN
    expect_i  = 32'hA5A5A5A4;
    cmpmask_i = 32'h1;
`endif
    applyStimulus(0, 0, 3, 32'hFFFFFFFF, 32'h0000FFFF, 32'hA5A5A5A5);
    runAndScore("t1", 1'b0, 4);
    checkOutput("t1_datain", datain_o, 32'hA5A5A5A5);
`ifdef TINYTESTER_SEQ_COMPARE_EN
    checkOutput("t1_mismatch", WIDTH'(mismatch_o), 32'h1);
`endif
    @(negedge clk);
    checkOutput("t1_idle", WIDTH'(state_o), 32'h1);

    $display("[TB] test 2: hold and repeat");
`ifdef TINYTESTER_SEQ_COMPARE_EN
    expect_i  = 32'h12345678;
    cmpmask_i = 32'hFFFFFFFF;
`endif
    applyStimulus(2, 1, 1, 32'hFFFFFFFF, 32'hFFFF0000, 32'h12345678);
    runAndScore("t2", 1'b0, 24);
    checkOutput("t2_datain", datain_o, 32'h12345678);
`ifdef TINYTESTER_SEQ_COMPARE_EN
    checkOutput("t2_mismatch", WIDTH'(mismatch_o), 32'h0);
`endif
    @(negedge clk);
    checkOutput("t2_idle", WIDTH'(state_o), 32'h1);

    $display("[TB] test 3: abort in phase 1");
    applyStimulus(3, 0, 3, 32'hFFFFFFFF, 32'h0000FFFF, 32'h0BADBEEF);
    @(negedge clk);
    start_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checkOutput("t3_busy", WIDTH'(busy_o), 32'h1);
      checkOutput("t3_padout", padout_o, sb.pop_front());
      if (i == 5) abort_i = 1'b1;
      else @(negedge clk);
    end
    @(negedge clk);
    abort_i = 1'b0;
    checkOutput("t3_padoe", padoe_o, 32'h0);
    checkOutput("t3_state", WIDTH'(state_o), 32'h4);
    checkOutput("t3_datain", datain_o, 32'h12345678);
    checkOutput("t3_padout_hold", padout_o, 32'h2);
    sb.delete();
    @(negedge clk);
    checkOutput("t3_idle", WIDTH'(state_o), 32'h1);

    $display("[TB] test 4: capture phase out of range");
    applyStimulus(0, 0, 7, 32'hFFFFFFFF, 32'h00FF00FF, 32'h55555555);
    runAndScore("t4", 1'b0, 4);
    checkOutput("t4_datain", datain_o, 32'h12345678);
    @(negedge clk);
    checkOutput("t4_idle", WIDTH'(state_o), 32'h1);

    $display("[TB] test 5: start held after run");
    applyStimulus(1, 0, 0, 32'h0F0F0F0F, 32'hFFFFFFFF, 32'hCAFEF00D);
    runAndScore("t5", 1'b1, 8);
    repeat (5) begin
      @(negedge clk);
      checkOutput("t5_hold_wait", WIDTH'(state_o), 32'h4);
      checkOutput("t5_no_rerun", WIDTH'(busy_o), 32'h0);
    end
    start_i = 1'b0;
    @(negedge clk);
    checkOutput("t5_idle", WIDTH'(state_o), 32'h1);
    checkOutput("t5_datain", datain_o, 32'hCAFEF00D);
    applyStimulus(0, 0, 2, 32'hFFFFFFFF, 32'h000000FF, 32'h00C0FFEE);
    runAndScore("t5b", 1'b0, 4);
    checkOutput("t5b_datain", datain_o, 32'h00C0FFEE);
    @(negedge clk);
    checkOutput("t5b_idle", WIDTH'(state_o), 32'h1);

    $display("[TB] test 6: reset mid-run");
`ifdef TINYTESTER_SEQ_COMPARE_EN
    expect_i  = 32'hA5A5A5A4;
    cmpmask_i = 32'h1;
`endif
    applyStimulus(3, 1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hA5A5A5A5);
    @(negedge clk);
    start_i = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("t6_busy", WIDTH'(busy_o), 32'h1);
    checkOutput("t6_datain_pre", datain_o, 32'hA5A5A5A5);
`ifdef TINYTESTER_SEQ_COMPARE_EN
    checkOutput("t6_mismatch_pre", WIDTH'(mismatch_o), 32'h1);
`endif
    #2 rst = 1'b1;
    #1;
    checkOutput("t6_state", WIDTH'(state_o), 32'h1);
    checkOutput("t6_padout", padout_o, 32'h0);
    checkOutput("t6_padoe", padoe_o, 32'h0);
    checkOutput("t6_datain", datain_o, 32'h0);
    checkOutput("t6_busy0", WIDTH'(busy_o), 32'h0);
    checkOutput("t6_done0", WIDTH'(done_o), 32'h0);
`ifdef TINYTESTER_SEQ_COMPARE_EN
    checkOutput("t6_mismatch", WIDTH'(mismatch_o), 32'h0);
`endif
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("t6_idle", WIDTH'(state_o), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tinytester_seq.md
Name: tinytester_seq

Overview:
- Parametrised successor to the 4-phase pad tinytester.
- Drives a WIDTH-bit pad bus through NUM_PHASES programmable phases, with:
  - a programmable hold time per phase,
  - a programmable repeat count,
  - a selectable capture phase,
  - an abort input.
- Sits between the AHB/Wishbone register bank (control/data registers) and the FPGA pad ring (padout/padoe/padin).

Parameters:
- WIDTH, 32, pad bus width.
- NUM_PHASES, 4, phases per iteration (2..16).
- PH_W, 4, width of the phase index and capture_phase_i; must satisfy 2**PH_W >= NUM_PHASES.
- LEN_W, 8, width of the per-phase hold-length field.
- REP_W, 16, width of the repeat-count field.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- start_i  in  1  level; 1 in IDLE starts a run; must return to 0 before a new run.
- abort_i  in  1  level; terminates a run.
- phase_len_i  in  LEN_W  each phase lasts phase_len_i+1 cycles; latched at start.
- repeat_i  in  REP_W  number of iterations = repeat_i+1; latched at start.
- capture_phase_i  in  PH_W  phase whose last cycle samples padin; latched at start.
- dataout_i  in  WIDTH  output pattern.
- oe_i  in  WIDTH  pad output enables.
- active_on_i  in  NUM_PHASES*WIDTH  per-phase mask; slice k = bits [k*WIDTH +: WIDTH].
- padout_o  out  WIDTH  pad output data.
- padoe_o  out  WIDTH  pad output enable.
- padin_i  in  WIDTH  pad input.
- datain_o  out  WIDTH  captured pad input.
- busy_o  out  1  high in RUN.
- done_o  out  1  high in WAIT.
- state_o  out  3  one-hot state: {WAIT, RUN, IDLE}.

Behaviour:
- Reset values:
  - state = IDLE (state_o = 3'b001).
  - padout_o, padoe_o, datain_o = 0.
  - busy_o, done_o = 0.
  - All counters = 0.
- IDLE:
  - start_i=0: remain in IDLE.
  - start_i=1, at that edge:
    - latch phase_len_i, repeat_i and capture_phase_i.
    - phase index = 0, hold counter = 0, iteration counter = 0.
    - padout_o <= dataout_i & active_on[0]; padoe_o <= oe_i.
    - Enter RUN. First pad drive therefore appears 1 cycle after start_i is seen high.
- RUN, each cycle:
  - Hold counter increments until it equals the latched length.
  - At the last cycle of a phase:
    - If the phase equals the latched capture phase: datain_o <= padin_i.
    - If the phase < NUM_PHASES-1: advance the phase; padout_o <= dataout_i & active_on[phase+1]; hold counter = 0.
    - If the phase = NUM_PHASES-1 and iteration < repeat: iteration+1, phase = 0, padout_o <= dataout_i & active_on[0].
    - Otherwise: enter WAIT.
  - dataout_i, oe_i and active_on_i are sampled live at each phase entry. padoe_o updates only at the start of a run.
- Capture rules:
  - Capture happens in every iteration; datain_o therefore holds the final iteration's value.
  - If the latched capture phase >= NUM_PHASES, no capture occurs and datain_o retains its value.
- WAIT:
  - padout_o and padoe_o hold their last values.
  - start_i=1: remain in WAIT.
  - start_i=0: enter IDLE.
- Abort:
  - abort_i=1 in RUN: at the next edge padoe_o <= 0, datain_o is unchanged, state goes to WAIT.
  - abort_i is ignored in IDLE and WAIT.
  - abort_i has priority over the phase advance and the capture on the same cycle.
- Cycle counts:
  - Run length = (phase_len+1) * NUM_PHASES * (repeat+1) cycles in RUN.
  - Minimum case (len=0, rep=0) = NUM_PHASES cycles, the same timing as the original block.
- Illegal state encodings return to IDLE.
- rst asserted mid-run returns all outputs to their reset values immediately.

Optional Feature:
- Macro TINYTESTER_SEQ_COMPARE_EN.
- When defined, add these ports:
  - expect_i (in, WIDTH).
  - cmpmask_i (in, WIDTH).
  - mismatch_o (out, 1, sticky).
- At each capture, mismatch_o is set if ((padin_i ^ expect_i) & cmpmask_i) != 0.
- mismatch_o is cleared when a run starts and at reset.
- When undefined, none of these ports or logic exist.

Decomposition:
- Package tinytester_pkg holds:
  - state localparams ST_IDLE = 3'b001, ST_RUN = 3'b010, ST_WAIT = 3'b100.
  - Default parameter constants.
- One natural sub-module: tinytester_phase_ctr. It contains the hold, phase and iteration counters and outputs phase_idx, phase_last, run_last.

Test Plan (WIDTH=32, NUM_PHASES=4):
1. Basic run.
   - Stimulus: len=0, rep=0, cap=3, dataout=FFFFFFFF, oe=0000FFFF, masks 1/2/4/8, padin=A5A5A5A5; pulse start high.
   - Required: padout = 1, 2, 4, 8 on consecutive cycles; padoe = 0000FFFF; datain = A5A5A5A5; done after 4 RUN cycles; start low returns to IDLE.
2. Hold and repeat.
   - Stimulus: len=2, rep=1.
   - Required: each mask held 3 cycles; sequence repeats twice; busy high exactly 24 cycles.
3. Abort.
   - Stimulus: abort_i=1 during phase 1 of a len=3 run.
   - Required: padoe = 0 next cycle; state WAIT; datain unchanged.
4. Capture phase out of range.
   - Stimulus: cap=7.
   - Required: run completes; datain keeps its previous value.
5. Start held high after a run.
   - Stimulus: keep start_i=1 after the run ends.
   - Required: stays in WAIT with no rerun; a new run starts only after start drops to 0 and rises again.
6. Reset mid-RUN and compare.
   - Stimulus: assert rst during RUN.
   - Required: all outputs return to 0 immediately.
   - With TINYTESTER_SEQ_COMPARE_EN: expect=A5A5A5A4, mask=1, padin=A5A5A5A5 gives mismatch_o=1.
